// File: rtl/traffic_pkg.sv
// Shared types and light codes for the traffic phase scheduler.
// TRAFFIC_PED_EN adds the pedestrian walk phase to the state set.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    A_GREEN,
    A_YELLOW,
    AR_AB,
    B_GREEN,
    B_YELLOW,
    AR_BA
`ifdef TRAFFIC_PED_EN
    , PED_WALK
`endif
  } phase_e;

endpackage

// File: rtl/traffic_phase_timer.sv
// Per-phase tick counter: cleared on phase change, optionally saturating
// at SAT so a resting green never wraps.
module phase_timer #(
  parameter int CNT_W = 8,
  parameter int SAT   = 29
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             tick,
  input  logic             sat_en,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick && !(sat_en && cnt == SAT_V)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Actuated two-street phase scheduler: sensor-driven green termination, yellow
// and all-red sequencing, optional pedestrian walk (macro TRAFFIC_PED_EN).
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int G_MIN    = 5,
  parameter int G_MAX    = 30,
  parameter int Y_TIME   = 3,
  parameter int AR_TIME  = 1,
  parameter int PED_TIME = 10,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       sensor_a,
  input  logic       sensor_b,
  input  logic       ped_req,
  output logic [2:0] street_a,
  output logic [2:0] street_b,
  output logic       walk,
  output logic       ped_wait
);

  localparam longint CNT_SPAN = longint'(1) << CNT_W;

  if (G_MIN < 1 || G_MAX < 1 || Y_TIME < 1 || AR_TIME < 1 || PED_TIME < 1 ||
      G_MIN > CNT_SPAN || G_MAX > CNT_SPAN || Y_TIME > CNT_SPAN ||
      AR_TIME > CNT_SPAN || PED_TIME > CNT_SPAN || G_MIN > G_MAX) begin : g_bad_params
    $error("traffic_phase_scheduler: illegal timing parameters");
  end

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(G_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(G_MAX - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(Y_TIME - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(AR_TIME - 1);

  phase_e           state, state_nx;
  phase_e           exit_ab, exit_ba;
  logic [CNT_W-1:0] cnt;
  logic             green, min_done, max_done, ped_pending;

  assign green    = (state == A_GREEN) || (state == B_GREEN);
  assign min_done = cnt >= GMIN_LAST;
  assign max_done = cnt == GMAX_LAST;

  phase_timer #(
    .CNT_W (CNT_W),
    .SAT   (G_MAX - 1)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_nx != state),
    .tick   (tick),
    .sat_en (green),
    .cnt    (cnt)
  );

`ifdef TRAFFIC_PED_EN
  localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(PED_TIME - 1);

  logic ped_now, ped_go, next_is_b;

  // A request arriving on the all-red exit tick still diverts into the walk.
  assign ped_now = ped_req && (state != PED_WALK);
  assign ped_go  = ped_pending || ped_now;
  assign exit_ab = ped_go ? PED_WALK : B_GREEN;
  assign exit_ba = ped_go ? PED_WALK : A_GREEN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pending <= 1'b0;
      next_is_b   <= 1'b0;
    end else if (state_nx == PED_WALK && state != PED_WALK) begin
      ped_pending <= 1'b0;
      next_is_b   <= (state == AR_AB);
    end else if (ped_now) begin
      ped_pending <= 1'b1;
    end
  end

  assign walk     = (state == PED_WALK);
  assign ped_wait = ped_pending;
`else
  logic ped_req_unused;

  assign ped_req_unused = ped_req;
  assign ped_pending    = 1'b0;
  assign exit_ab        = B_GREEN;
  assign exit_ba        = A_GREEN;
  assign walk           = 1'b0;
  assign ped_wait       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= A_GREEN;
    else        state <= state_nx;
  end

  // NOTE: state_nx is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_nx = state;
    if (tick) begin
      case (state)
        A_GREEN:  if ((sensor_b || ped_pending) && min_done && (!sensor_a || max_done))
                    state_nx = A_YELLOW;
        A_YELLOW: if (cnt == Y_LAST)  state_nx = AR_AB;
        AR_AB:    if (cnt == AR_LAST) state_nx = exit_ab;
        B_GREEN:  if ((sensor_a || ped_pending) && min_done && (!sensor_b || max_done))
                    state_nx = B_YELLOW;
        B_YELLOW: if (cnt == Y_LAST)  state_nx = AR_BA;
        AR_BA:    if (cnt == AR_LAST) state_nx = exit_ba;
`ifdef TRAFFIC_PED_EN
        PED_WALK: if (cnt == PED_LAST) state_nx = next_is_b ? B_GREEN : A_GREEN;
`endif
        default:  state_nx = A_GREEN;
      endcase
    end
  end

  always_comb begin
    street_a = LIGHT_RED;
    street_b = LIGHT_RED;
    case (state)
      A_GREEN:  street_a = LIGHT_GREEN;
      A_YELLOW: street_a = LIGHT_YELLOW;
      B_GREEN:  street_b = LIGHT_GREEN;
      B_YELLOW: street_b = LIGHT_YELLOW;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: directed scenarios then random
// traffic, checked against a phase/elapsed-ticks reference model.
module tb_traffic_phase_scheduler;

  localparam int G_MIN = 3, G_MAX = 6, Y_TIME = 2, AR_TIME = 1, PED_TIME = 4, CNT_W = 8;
`ifdef TRAFFIC_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0;
  logic       sensor_a = 1'b0, sensor_b = 1'b0, ped_req = 1'b0;
  logic [2:0] street_a, street_b;
  logic       walk, ped_wait;

  traffic_phase_scheduler #(
    .G_MIN (G_MIN), .G_MAX (G_MAX), .Y_TIME (Y_TIME),
    .AR_TIME (AR_TIME), .PED_TIME (PED_TIME), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst_n (rst_n), .tick (tick),
    .sensor_a (sensor_a), .sensor_b (sensor_b), .ped_req (ped_req),
    .street_a (street_a), .street_b (street_b), .walk (walk), .ped_wait (ped_wait)
  );

  always #5 clk = ~clk;

  typedef enum {P_AG, P_AY, P_AR_AB, P_BG, P_BY, P_AR_BA, P_WALK} ph_t;
  ph_t        m_ph;
  int         m_elapsed;
  bit         m_pend, m_walk_to_b;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int         n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [2:0] a = 3'b100;
    logic [2:0] b = 3'b100;
    case (m_ph)
      P_AG: a = 3'b001;
      P_AY: a = 3'b010;
      P_BG: b = 3'b001;
      P_BY: b = 3'b010;
      default: ;
    endcase
    return {a, b, (m_ph == P_WALK), m_pend};
  endfunction

  function automatic void model_reset();
    m_ph = P_AG; m_elapsed = 0; m_pend = 1'b0; m_walk_to_b = 1'b0;
  endfunction

  // Phases are tracked as "ticks spent so far"; a phase of length N ends on its N-th tick.
  function automatic void model_step(input bit tk, input bit sa, input bit sb, input bit pr);
    bit  ped_now = PED_EN && pr && (m_ph != P_WALK);
    ph_t nxt = m_ph;
    int  e;
    if (tk) begin
      e = m_elapsed + 1;
      case (m_ph)
        P_AG:    if ((sb || m_pend) && e >= G_MIN && (!sa || e >= G_MAX)) nxt = P_AY;
        P_BG:    if ((sa || m_pend) && e >= G_MIN && (!sb || e >= G_MAX)) nxt = P_BY;
        P_AY:    if (e >= Y_TIME) nxt = P_AR_AB;
        P_BY:    if (e >= Y_TIME) nxt = P_AR_BA;
        P_AR_AB: if (e >= AR_TIME) begin
                   if (m_pend || ped_now) begin nxt = P_WALK; m_walk_to_b = 1'b1; end
                   else nxt = P_BG;
                 end
        P_AR_BA: if (e >= AR_TIME) begin
                   if (m_pend || ped_now) begin nxt = P_WALK; m_walk_to_b = 1'b0; end
                   else nxt = P_AG;
                 end
        P_WALK:  if (e >= PED_TIME) nxt = m_walk_to_b ? P_BG : P_AG;
        default: nxt = P_AG;
      endcase
      m_elapsed = (nxt != m_ph) ? 0 : e;
    end
    if (nxt == P_WALK && m_ph != P_WALK) m_pend = 1'b0;
    else if (ped_now)                    m_pend = 1'b1;
    m_ph = nxt;
  endfunction

  task automatic step(input bit tk, input bit sa, input bit sb, input bit pr);
    @(negedge clk);
    rst_n = 1'b1; tick = tk; sensor_a = sa; sensor_b = sb; ped_req = pr;
    model_step(tk, sa, sb, pr);
    exp_q.push_back(model_out());
  endtask

  // Reset is asserted mid-cycle and its effect checked before any clock edge.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; ped_req = 1'b0;
    #1;
    check("async_street_a", street_a, 3'b001);
    check("async_street_b", street_b, 3'b100);
    check("async_walk", walk, 1'b0);
    check("async_ped_wait", ped_wait, 1'b0);
    model_reset();
    exp_q.push_back(model_out());
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("street_a", street_a, mon_exp[7:5]);
        check("street_b", street_b, mon_exp[4:2]);
        check("walk", walk, mon_exp[1]);
        check("ped_wait", ped_wait, mon_exp[0]);
      end
    end
  end

  initial begin
    bit hit, walk_req_done, sa_r, sb_r, tk, pr;
    model_reset();
    apply_reset();
    apply_reset();

    repeat (100) step(1, 0, 0, 0);
    repeat (15)  step(1, 0, 1, 0);
    repeat (30)  step(1, 1, 1, 0);

    repeat (12) step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    walk_req_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      pr = (m_ph == P_WALK) && !walk_req_done;
      if (pr) walk_req_done = 1'b1;
      step(1, 0, 0, pr);
    end

    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_ph == P_BY) hit = 1'b1;
      else step(1, 1, 1, (m_ph == P_BG));
    end
    check("reach_b_yellow", hit, 1'b1);
    apply_reset();

    repeat (50) step(0, 0, 1, 0);
    repeat (15) step(1, 0, 1, 0);

    sa_r = 1'b0; sb_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) sa_r = ~sa_r;
      if ($urandom_range(0, 19) == 0) sb_r = ~sb_r;
      tk = ($urandom_range(0, 3) != 0);
      pr = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 999) == 0) apply_reset();
      else step(tk, sa_r, sb_r, pr);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
